// File: rtl/addsub_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic {IDLE, RUN} addsub_state_t;

  // Number of chunk cycles per operation.
  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit so N==1 still has a legal counter.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/response bundle for the serial adder/subtractor.
interface addsub_serial_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic             sat;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             zero;

  modport master (output start, sub, sat, a, b,
                  input  busy, done, sum, cout, ovfl, zero);
  modport slave  (input  start, sub, sat, a, b,
                  output busy, done, sum, cout, ovfl, zero);
endinterface

// File: rtl/addsub_serial_chunk.sv
// CHUNK-bit ripple-carry adder built from 1-bit full adder cells.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb   // carry into the top bit, for overflow cross-check
);
  logic [CHUNK:0] c;

  assign c[0] = c_in;

  fulladder u_fa [CHUNK-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[CHUNK-1:0]),
    .s  (sum),
    .co (c[CHUNK:1])
  );

  assign c_out = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, CHUNK bits per clock,
// optional signed saturation, registered result and flags with done pulse.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  addsub_serial_if.slave  bus
);
  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int IW = calc_idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("addsub_serial: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  addsub_state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, part;
  logic             carry, sat_r;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] sum_r;
  logic             busy_r, done_r, cout_r, ovfl_r, zero_r;

  logic [CHUNK-1:0] csum;
  logic             c_out, c_msb, last, ovfl_raw;
  logic [WIDTH-1:0] raw, sat_val, fin;

  assign last = (idx == LAST);

  ripple_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_r[idx*CHUNK +: CHUNK]),
    .b     (b_r[idx*CHUNK +: CHUNK]),
    .c_in  (carry),
    .sum   (csum),
    .c_out (c_out),
    .c_msb (c_msb)
  );

  // Full raw result as it will stand once the current chunk is written.
  always_comb begin
    raw = part;
    raw[idx*CHUNK +: CHUNK] = csum;
  end

  assign ovfl_raw = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (raw[WIDTH-1] != a_r[WIDTH-1]);
  assign sat_val  = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign fin      = (sat_r && ovfl_raw) ? sat_val : raw;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept in IDLE, return after the last chunk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, chunk accumulation and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      part   <= '0;
      carry  <= 1'b0;
      sat_r  <= 1'b0;
      idx    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovfl_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b ^ {WIDTH{bus.sub}};
            carry  <= bus.sub;
            sat_r  <= bus.sat;
            idx    <= '0;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          part[idx*CHUNK +: CHUNK] <= csum;
          carry <= c_out;
          if (last) begin
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            sum_r  <= fin;
            cout_r <= c_out;
            ovfl_r <= ovfl_raw;
            zero_r <= (fin == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sign-rule overflow must agree with the carry-in/carry-out rule at the MSB.
  a_ovfl_xcheck: assert property (@(posedge clk) disable iff (rst)
    (state == RUN && last) |-> (ovfl_raw == (c_msb ^ c_out)));

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovfl = ovfl_r;
  assign bus.zero = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: four instances (CHUNK 4,1,8,16) share one stimulus stream;
// each has its own transaction model and per-cycle output monitor.
module tb_addsub_serial;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic        zero;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  int stim_chk = 0;
  int stim_bad = 0;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t ref_calc(input logic [15:0] ia, input logic [15:0] ib,
                                    input logic isub, input logic isat);
    exp_t r;
    int sa, sb, ua, ub, ex, rw;
    logic [15:0] rs;
    sa = $signed(ia);
    sb = $signed(ib);
    ua = ia;
    ub = ib;
    ex = isub ? sa - sb : sa + sb;
    rw = isub ? ua - ub : ua + ub;
    rs = 16'(rw);
    r.ovfl = (ex > 32767) || (ex < -32768);
    r.cout = isub ? (ua >= ub) : (ua + ub > 65535);
    r.sum  = (isat && r.ovfl) ? ((ex < 0) ? 16'h8000 : 16'h7FFF) : rs;
    r.zero = (r.sum == 16'h0000);
    r.due  = 0;
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
    localparam int N  = 16 / CH;

    addsub_serial_if #(.WIDTH(16)) bus ();
    assign bus.start = start;
    assign bus.sub   = sub;
    assign bus.sat   = sat;
    assign bus.a     = a;
    assign bus.b     = b;

    addsub_serial #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    exp_t        q[$];
    exp_t        e;
    int          t = 0;
    int          ls = -1000;
    logic        e_done = 1'b0, e_busy = 1'b0;
    logic [15:0] e_sum = '0;
    logic        e_cout = 1'b0, e_ovfl = 1'b0, e_zero = 1'b0;
    int          nvec = 0;
    int          nbad = 0;

    // Transaction model: accepts when idle, result due N edges later.
    always @(posedge clk) begin
      t = t + 1;
      if (rst) begin
        q.delete();
        ls = -1000;
        e_done = 1'b0;
        e_sum = '0;
        e_cout = 1'b0;
        e_ovfl = 1'b0;
        e_zero = 1'b0;
      end else begin
        e_done = 1'b0;
        if (q.size() > 0 && q[0].due == t) begin
          e = q.pop_front();
          e_done = 1'b1;
          e_sum  = e.sum;
          e_cout = e.cout;
          e_ovfl = e.ovfl;
          e_zero = e.zero;
        end
        if (start && t > ls + N) begin
          e = ref_calc(a, b, sub, sat);
          e.due = t + N;
          q.push_back(e);
          ls = t;
        end
      end
      e_busy = (t >= ls) && (t < ls + N);
    end

    // Monitor: compare every output every cycle away from the active edge.
    always @(negedge clk) begin
      if (t > 0) begin
        nvec++;
        if (bus.done !== e_done || bus.busy !== e_busy || bus.sum !== e_sum ||
            bus.cout !== e_cout || bus.ovfl !== e_ovfl || bus.zero !== e_zero) begin
          nbad++;
          $display("FAIL chunk%0d cyc%0d: got done=%0b busy=%0b sum=%h cout=%0b ovfl=%0b zero=%0b, want done=%0b busy=%0b sum=%h cout=%0b ovfl=%0b zero=%0b",
                   CH, t, bus.done, bus.busy, bus.sum, bus.cout, bus.ovfl, bus.zero,
                   e_done, e_busy, e_sum, e_cout, e_ovfl, e_zero);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub, input logic isat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; sat = isat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((gen_dut[0].bus.busy || gen_dut[1].bus.busy ||
            gen_dut[2].bus.busy || gen_dut[3].bus.busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    stim_chk++;
    if (k >= 200) begin
      stim_bad++;
      $display("FAIL idle_timeout: busy still %0b%0b%0b%0b after 200 cycles, want 0000",
               gen_dut[0].bus.busy, gen_dut[1].bus.busy,
               gen_dut[2].bus.busy, gen_dut[3].bus.busy);
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int vecs, bad;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0); wait_idle();
    issue(16'h0005, 16'h0007, 1'b1, 1'b0); wait_idle();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_idle();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1); wait_idle();
    issue(16'h8000, 16'h0001, 1'b1, 1'b1); wait_idle();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_idle();

    // Start while busy is ignored (new operands must not leak in)
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-run aborts without a done pulse
    issue(16'h4321, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    // Start held high: back-to-back acceptance on each done cycle
    for (int i = 0; i < 24; i++) begin
      a = pick(); b = pick(); sub = 1'($urandom); sat = 1'($urandom); start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      a = pick(); b = pick(); sub = 1'($urandom); sat = 1'($urandom);
      start = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    vecs = gen_dut[0].nvec + gen_dut[1].nvec + gen_dut[2].nvec + gen_dut[3].nvec + stim_chk;
    bad  = gen_dut[0].nbad + gen_dut[1].nbad + gen_dut[2].nbad + gen_dut[3].nbad + stim_bad;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
